// File: rtl/add_arb_pkg.sv
// ============================================================================
// Module  : add_arb_pkg
// Brief   : Shared types, widths and round-robin pick helper for add_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package add_arb_pkg;

    localparam int ADD_W     = 32;
    localparam int MAX_REQ   = 64;
    localparam int PICK_IDXW = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [PICK_IDXW-1:0] idx;
    } rr_pick_t;

    // Lowest index at or above ptr holding a valid request, wrapping mod nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input int                 nreq,
                                         input int                 ptr);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < nreq && !r.found) begin
                j = ptr + i;
                if (j >= nreq) j = j - nreq;
                if (valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = PICK_IDXW'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_arbiter_cla.sv
// ============================================================================
// Module  : cla_add32
// Brief   : W-bit carry-look-ahead adder built from 4-bit lookahead groups.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_add32
    import add_arb_pkg::*;
#(
    parameter int W = ADD_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    // W is expected to be a multiple of 4.
    localparam int NGRP = W / 4;

    logic [W-1:0]    w_g;
    logic [W-1:0]    w_p;
    logic [NGRP-1:0] w_gg;
    logic [NGRP-1:0] w_gp;
    logic [W:0]      w_c;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        assign w_gg[k] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        assign w_gp[k] = &w_p[4*k +: 4];
    end

    // Group carries chain across groups; bit carries are flat lookahead within a group.
    always_comb begin
        w_c    = '0;
        w_c[0] = ci_i;
        for (int k = 0; k < NGRP; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
        end
    end

    assign sum_o  = a_i ^ b_i ^ w_c[W-1:0];
    assign cout_o = w_c[W];
    assign cmsb_o = w_c[W-1];

endmodule

`default_nettype wire

// File: rtl/add_arbiter.sv
// ============================================================================
// Module  : add_arbiter
// Brief   : Round-robin shared adder with multi-word carry chaining and a
//           registered response. Define ADD_ARB_OVF_EN to add rsp_ovf.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ADD_W,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ-1:0]   req_last,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout
`ifdef ADD_ARB_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           chain_q, chain_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;

    logic [MAX_REQ-1:0] w_valid_ext;
    rr_pick_t           w_pick;
    logic               w_gnt;
    logic [IDW-1:0]     w_gnt_idx;
    logic               w_fire;
    logic [W-1:0]       w_a, w_b, w_b_eff, w_sum;
    logic               w_cin, w_sub, w_last, w_ci, w_cout, w_cmsb;

    always_comb begin
        w_valid_ext            = '0;
        w_valid_ext[NREQ-1:0]  = req_valid;
    end

    assign w_pick = rr_pick(w_valid_ext, NREQ, int'(ptr_q));

    always_comb begin
        if (state_q == ST_LOCK) begin
            w_gnt     = req_valid[owner_q];
            w_gnt_idx = owner_q;
        end else begin
            w_gnt     = w_pick.found;
            w_gnt_idx = IDW'(w_pick.idx);
        end
    end

    assign w_fire = w_gnt & (~rsp_valid_q | rsp_ready);

    always_comb begin
        req_ready = '0;
        w_a       = '0;
        w_b       = '0;
        w_cin     = 1'b0;
        w_sub     = 1'b0;
        w_last    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                req_ready[i] = w_fire;
                w_a          = req_a[i*W +: W];
                w_b          = req_b[i*W +: W];
                w_cin        = req_cin[i];
                w_sub        = req_sub[i];
                w_last       = req_last[i];
            end
        end
    end

    // Subtraction is A + ~B + 1; the first-beat cin acts as a borrow.
    assign w_b_eff = w_sub ? ~w_b : w_b;
    assign w_ci    = (state_q == ST_LOCK) ? chain_q : (w_cin ^ w_sub);

    cla_add32 #(.W(W)) u_cla (
        .a_i    (w_a),
        .b_i    (w_b_eff),
        .ci_i   (w_ci),
        .sum_o  (w_sum),
        .cout_o (w_cout),
        .cmsb_o (w_cmsb)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        chain_d     = chain_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (w_fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = w_gnt_idx;
            rsp_sum_d   = w_sum;
            rsp_cout_d  = w_cout;
            if (w_last) begin
                state_d = ST_IDLE;
                ptr_d   = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end else begin
                state_d = ST_LOCK;
                owner_d = w_gnt_idx;
                chain_d = w_cout;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            chain_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            chain_q     <= chain_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ADD_ARB_OVF_EN
    logic rsp_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf_q <= 1'b0;
        end else if (w_fire) begin
            rsp_ovf_q <= w_cmsb ^ w_cout;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    logic w_unused_cmsb;
    assign w_unused_cmsb = w_cmsb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_arbiter.sv
// ============================================================================
// Module  : tb_add_arbiter
// Brief   : Directed self-checking bench for add_arbiter (NREQ=4, W=32).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_cin = '0;
    logic [3:0]   req_sub = '0;
    logic [3:0]   req_last = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
`ifdef ADD_ARB_OVF_EN
    logic         rsp_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    add_arbiter #(.NREQ(4), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADD_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic last);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_cin[i]        = cin;
        req_sub[i]        = sub;
        req_last[i]       = last;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_sum !== 32'h0) begin n_err++; $display("FAIL reset_sum: got %h want 0", rsp_sum); end
        n_cmp++; if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", rsp_cout); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        set_req(0, 32'h5, 32'h3, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL add_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL add_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'h8) begin n_err++; $display("FAIL add_sum: got %h want 00000008", rsp_sum); end
        n_cmp++; if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL add_cout: got %b want 0", rsp_cout); end
    endtask

    task automatic test_subtract();
        set_req(1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1);
        tick();
        req_valid = '0;
        n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL sub_id: got %0d want 1", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sub_sum: got %h want ffffffff", rsp_sum); end
        n_cmp++; if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL sub_cout: got %b want 0", rsp_cout); end
        set_req(1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        tick();
        req_valid = '0;
        n_cmp++; if (rsp_sum !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL subov_sum: got %h want 7fffffff", rsp_sum); end
        n_cmp++; if (rsp_cout !== 1'b1) begin n_err++; $display("FAIL subov_cout: got %b want 1", rsp_cout); end
`ifdef ADD_ARB_OVF_EN
        n_cmp++; if (rsp_ovf !== 1'b1) begin n_err++; $display("FAIL subov_ovf: got %b want 1", rsp_ovf); end
`endif
    endtask

    task automatic test_chain();
        set_req(0, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
        set_req(3, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1);
        set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL chain_gnt0: got %b want 0100", req_ready); end
        tick();
        n_cmp++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin
            n_err++; $display("FAIL chain_beat0: got sum=%h cout=%b id=%0d want 0/1/2", rsp_sum, rsp_cout, rsp_id); end
        req_valid[2] = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL chain_starve: got %b want 0000", req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL chain_idle_rsp: got %b want 0", rsp_valid); end
        set_req(2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL chain_gnt1: got %b want 0100", req_ready); end
        tick();
        n_cmp++; if (rsp_sum !== 32'h1 || rsp_cout !== 1'b0 || rsp_id !== 2'd2) begin
            n_err++; $display("FAIL chain_beat1: got sum=%h cout=%b id=%0d want 1/0/2", rsp_sum, rsp_cout, rsp_id); end
        req_valid[2] = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL chain_next: got %b want 1000", req_ready); end
        tick();
        n_cmp++; if (rsp_id !== 2'd3 || rsp_sum !== 32'h77) begin
            n_err++; $display("FAIL chain_req3: got id=%0d sum=%h want 3/00000077", rsp_id, rsp_sum); end
        req_valid[3] = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL chain_req0: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 32'(k + 1), 32'h100, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(n % 4) || rsp_sum !== 32'(32'h101 + n % 4)) begin
                n_err++; $display("FAIL rr_%0d: got v=%b id=%0d sum=%h want 1/%0d/%h", n, rsp_valid, rsp_id, rsp_sum, n % 4, 32'h101 + n % 4); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 32'(k + 1), 32'h100, 1'b0, 1'b0, 1'b1);
        tick();
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready0: got %b want 0000", req_ready); end
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h101 || req_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_hold_%0d: got v=%b id=%0d sum=%h rdy=%b want 1/0/00000101/0000", n, rsp_valid, rsp_id, rsp_sum, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release: got %b want 0010", req_ready); end
        for (int n = 1; n <= 4; n++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(n % 4)) begin
                n_err++; $display("FAIL bp_seq_%0d: got v=%b id=%0d want 1/%0d", n, rsp_valid, rsp_id, n % 4); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_cout !== 1'b1) begin
            n_err++; $display("FAIL rml_beat0: got v=%b cout=%b want 1/1", rsp_valid, rsp_cout); end
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rml_valid: got %b want 0", rsp_valid); end
        set_req(1, 32'h9, 32'h9, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rml_idle: got %b want 0010", req_ready); end
        req_valid = '0;
        set_req(0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b1);
        tick();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h2 || rsp_cout !== 1'b0) begin
            n_err++; $display("FAIL rml_fresh: got v=%b sum=%h cout=%b want 1/00000002/0", rsp_valid, rsp_sum, rsp_cout); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_subtract();
        test_chain();
        test_round_robin();
        test_backpressure();
        test_reset_mid_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
